ram_stream_loader: RTL and testbench
====================================

Name: ram_stream_loader

Overview:
- Byte-stream to word-write loader sitting directly upstream of the on-chip program RAM (single-port, 32-bit, 10240 words, byte-enabled, no waitrequest).
- Accepts bytes from a valid/ready source such as a UART RX or a JTAG byte pipe.
- Packs bytes little-endian into 32-bit words and writes them to consecutive word addresses.
- Used to load program/data images without the CPU; RAM access is arbitrated by an external mux via mem_grant.

Parameters:
- ADDR_W, 14, RAM word-address width
- DEPTH, 10240, number of RAM words; the last valid address is DEPTH-1
- LEN_W, 16, width of the byte-length field

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin a load; sampled only in IDLE
- base_addr  in  ADDR_W  first word address, latched on start
- len_bytes  in  LEN_W  number of bytes to load, latched on start
- s_data  in  8  stream byte
- s_valid  in  1  stream byte valid
- s_ready  out  1  loader accepts a byte this cycle
- mem_grant  in  1  arbiter grants the RAM port this cycle
- m_address  out  ADDR_W  RAM word address
- m_byteenable  out  4  lanes written
- m_writedata  out  32  packed word
- m_chipselect  out  1  RAM select
- m_write  out  1  RAM write strobe
- busy  out  1  load in progress
- done  out  1  one-cycle pulse at load end
- err_overflow  out  1  sticky; set when the image runs past DEPTH-1; cleared by the next accepted start

Behaviour:
- Reset values (asynchronous):
  - all outputs 0
  - state IDLE
  - byte lane counter 0
  - byte remaining count 0
  - word buffer 0
- States:
  - IDLE: on start, latch base_addr, len_bytes and clear err_overflow.
    - len_bytes==0 -> DONE.
    - base_addr>DEPTH-1 -> set err_overflow, -> DONE.
    - otherwise -> COLLECT.
  - COLLECT: s_ready=1.
    - On s_valid&s_ready, place s_data in lane = lane counter (byte 0 -> bits 7:0), set the matching bit of a pending-enable mask, increment the lane counter, decrement the remaining count.
    - Go to WRITE after the 4th byte of a word or the last byte of the image.
  - WRITE: s_ready=0. m_address, m_writedata and m_byteenable (the pending mask) are held stable.
    - m_chipselect and m_write are asserted only while mem_grant=1, for exactly one cycle.
    - If mem_grant=0, stay in WRITE with the strobes low.
    - After the strobe cycle, clear the mask and lane counter.
    - If remaining==0 -> DONE.
    - Else if m_address==DEPTH-1 -> set err_overflow, -> DONE. Remaining stream bytes are not consumed.
    - Else increment m_address and -> COLLECT.
  - DONE: done=1 for one cycle, busy=0, -> IDLE.
- busy=1 in COLLECT and WRITE.
- start outside IDLE is ignored.
- Unfilled lanes of a partial final word have byteenable 0; their writedata is don't-care, driven 0.
- Timing:
  - Throughput with no stalls: 4 bytes per 5 cycles.
  - The strobe occurs the cycle after the last byte of a word is accepted.
  - The RAM read latency is irrelevant; the block never reads.
- Arithmetic: the remaining count is LEN_W bits and never underflows; the address never wraps.
- Reset mid-load: immediate return to IDLE; any partial word is discarded and never written.
- s_valid held high with no load active: s_ready stays 0 and bytes are not consumed.

Optional Feature:
- Macro: RAM_STREAM_LOADER_CHECKSUM_EN
- With the macro:
  - Adds output checksum[31:0], reset 0 and cleared on an accepted start.
  - On each byte accept, checksum <= checksum + zero-extended s_data, modulo 2^32.
  - Valid when done pulses.
- Without the macro: the port and logic are absent.

Decomposition:
- Shared package (ram_loader_pkg):
  - state enum {IDLE, COLLECT, WRITE, DONE}
  - constants RAM_DEPTH=10240, RAM_ADDR_W=14, RAM_DATA_W=32, RAM_BE_W=4
- One natural sub-module, byte_packer: lane counter, word buffer and enable mask, with load/flush/clear controls. The FSM, address counter and length counter stay in the top.

Test Plan:
- Base 0x0100, len 8, bytes 0x11..0x88, grant always 1 -> writes 0x44332211@0x0100 and 0x88776655@0x0101, both BE 0xF; done one cycle after the 2nd strobe; err_overflow 0.
- Base 0x0000, len 6, bytes 0xA0..0xA5 -> 2nd write @0x0001 has BE 0x3 and data 0x0000A5A4.
- Grant low for 3 cycles in WRITE -> address/data/BE stable, no strobe, s_ready 0; one strobe when grant rises.
- Base 0x27FF (DEPTH-1), len 8 -> one write @0x27FF, err_overflow=1, done pulses, 4 bytes left unconsumed.
- Reset asserted after 2 bytes of a word -> no write strobe, all outputs 0; a fresh start len 4 loads correctly.
- len 0 -> done next cycle, no strobe. With RAM_STREAM_LOADER_CHECKSUM_EN, a len-4 load of 0xFF x4 -> checksum 0x000003FC.

Source files
------------

// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg
// Shared definitions for the RAM stream loader: FSM state encoding and
// geometry of the on-chip program RAM (32-bit words, byte-enabled).
// Ports: none (package).
package ram_loader_pkg;

    localparam int RAM_DEPTH  = 10240;
    localparam int RAM_ADDR_W = 14;
    localparam int RAM_DATA_W = 32;
    localparam int RAM_BE_W   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/ram_stream_loader_byte_packer.sv
// byte_packer
// Packs bytes little-endian into one RAM word and tracks which lanes hold
// data. Lane 0 lands in bits 7:0.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load         place byte_in into the current lane and advance the lane
//   clear        empty the buffer: lane counter, word and mask back to 0
//   byte_in      byte to place
//   lane         current lane counter (0..3)
//   word         packed word; unfilled lanes read 0
//   byte_en      pending-enable mask, one bit per filled lane
module byte_packer
    import ram_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  clear,
    input  logic [7:0]            byte_in,
    output logic [1:0]            lane,
    output logic [RAM_DATA_W-1:0] word,
    output logic [RAM_BE_W-1:0]   byte_en
);

    logic [1:0]            lane_q, lane_d;
    logic [RAM_DATA_W-1:0] word_q, word_d;
    logic [RAM_BE_W-1:0]   be_q,   be_d;

    always_comb begin
        lane_d = lane_q;
        word_d = word_q;
        be_d   = be_q;
        // Clear wins so a partial word never leaks stale bytes into the next one.
        if (clear) begin
            lane_d = '0;
            word_d = '0;
            be_d   = '0;
        end else if (load) begin
            word_d[{lane_q, 3'b000} +: 8] = byte_in;
            be_d[lane_q]                  = 1'b1;
            lane_d                        = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= '0;
            word_q <= '0;
            be_q   <= '0;
        end else begin
            lane_q <= lane_d;
            word_q <= word_d;
            be_q   <= be_d;
        end
    end

    assign lane    = lane_q;
    assign word    = word_q;
    assign byte_en = be_q;

endmodule

// File: rtl/ram_stream_loader.sv
// ram_stream_loader
// Loads a byte stream into the program RAM without the CPU: bytes are packed
// little-endian into 32-bit words written to consecutive word addresses.
// Optional feature macro: RAM_STREAM_LOADER_CHECKSUM_EN adds a 32-bit running
// byte sum output (checksum), cleared on start, valid when done pulses.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               begin a load (sampled only while idle)
//   base_addr           first word address, latched on start
//   len_bytes           image length in bytes, latched on start
//   s_data/s_valid/s_ready  byte stream (valid/ready)
//   mem_grant           arbiter grants the RAM port this cycle
//   m_address, m_byteenable, m_writedata, m_chipselect, m_write  RAM write port
//   busy                load in progress
//   done                one-cycle pulse at load end
//   err_overflow        sticky: image ran past the last RAM word
module ram_stream_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DEPTH  = RAM_DEPTH,
    parameter int LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_addr,
    input  logic [LEN_W-1:0]      len_bytes,
    input  logic [7:0]            s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic                  mem_grant,
    output logic [ADDR_W-1:0]     m_address,
    output logic [RAM_BE_W-1:0]   m_byteenable,
    output logic [RAM_DATA_W-1:0] m_writedata,
    output logic                  m_chipselect,
    output logic                  m_write,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overflow
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]           checksum
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [LEN_W-1:0]  remain_q,  remain_d;
    logic              err_q,     err_d;
    logic              busy_q,    busy_d;
    logic              done_q,    done_d;
    logic              s_ready_q, s_ready_d;

    logic                  accept;
    logic                  strobe;
    logic                  pk_clear;
    logic [1:0]            pk_lane;
    logic [RAM_DATA_W-1:0] pk_word;
    logic [RAM_BE_W-1:0]   pk_be;

    // s_ready_q is 1 exactly when the FSM is in COLLECT.
    assign accept = s_ready_q && s_valid;
    // The strobe must follow the grant in the same cycle, so it is decoded
    // from the registered state and the live grant.
    assign strobe = (state_q == WRITE) && mem_grant;

    byte_packer u_packer (
        .clk     (clk),
        .reset   (reset),
        .load    (accept),
        .clear   (pk_clear),
        .byte_in (s_data),
        .lane    (pk_lane),
        .word    (pk_word),
        .byte_en (pk_be)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        err_d    = err_q;
        pk_clear = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d   = base_addr;
                    remain_d = len_bytes;
                    err_d    = 1'b0;
                    pk_clear = 1'b1;
                    if (len_bytes == '0) begin
                        state_d = DONE;
                    end else if (base_addr > LAST_ADDR) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    if (remain_q != '0) begin
                        remain_d = remain_q - LEN_W'(1);
                    end
                    // Word full or image exhausted: flush what we have.
                    if (pk_lane == 2'd3 || remain_q == LEN_W'(1)) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (mem_grant) begin
                    pk_clear = 1'b1;
                    if (remain_q == '0) begin
                        state_d = DONE;
                    end else if (addr_q == LAST_ADDR) begin
                        // Never wrap: stop and leave the rest of the stream alone.
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = COLLECT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Status outputs are registered from the next state so they line up
    // with the state register.
    always_comb begin
        busy_d    = (state_d == COLLECT) || (state_d == WRITE);
        done_d    = (state_d == DONE);
        s_ready_d = (state_d == COLLECT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            remain_q  <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            s_ready_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            remain_q  <= remain_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            s_ready_q <= s_ready_d;
        end
    end

`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (state_q == IDLE && start) begin
            checksum_d = '0;
        end else if (accept) begin
            checksum_d = checksum_q + {24'd0, s_data};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

    assign s_ready      = s_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err_overflow = err_q;
    assign m_address    = addr_q;
    assign m_writedata  = pk_word;
    assign m_byteenable = pk_be;
    assign m_chipselect = strobe;
    assign m_write      = strobe;

endmodule

// File: tb/tb_ram_stream_loader.sv
// tb_ram_stream_loader
// Directed bench for ram_stream_loader: a table of complete loads (base,
// length, byte pattern, expected writes / error / consumption) followed by
// hand-written grant-stall and reset-mid-load sequences.
module tb_ram_stream_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] base_addr;
    logic [15:0] len_bytes;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_ready;
    logic        mem_grant;
    logic [13:0] m_address;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic        m_chipselect;
    logic        m_write;
    logic        busy;
    logic        done;
    logic        err_overflow;
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    always #5 clk = ~clk;

    ram_stream_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .len_bytes    (len_bytes),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .mem_grant    (mem_grant),
        .m_address    (m_address),
        .m_byteenable (m_byteenable),
        .m_writedata  (m_writedata),
        .m_chipselect (m_chipselect),
        .m_write      (m_write),
        .busy         (busy),
        .done         (done),
        .err_overflow (err_overflow)
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    typedef struct {
        logic [13:0] base;
        logic [15:0] len;
        logic [7:0]  b0;
        logic [7:0]  step;
        int          exp_writes;
        logic [13:0] exp_addr_last;
        logic [31:0] exp_data_last;
        logic [3:0]  exp_be_last;
        logic        exp_err;
        int          exp_consumed;
    } vec_t;

    vec_t vecs[9];

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  src[16];
    int          nbytes;
    int          idx;
    int          tcount;
    int          nwr;
    int          ndone;
    int          done_cyc;
    int          last_wr_cyc;
    logic [13:0] wr_addr[8];
    logic [31:0] wr_data[8];
    logic [3:0]  wr_be[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // One clock cycle. Called at 2 time units after an edge; returns at the
    // same point of the next cycle with outputs settled.
    task automatic tick();
        logic acc;
        acc = s_valid && s_ready;
        if (m_write && m_chipselect) begin
            if (nwr < 8) begin
                wr_addr[nwr] = m_address;
                wr_data[nwr] = m_writedata;
                wr_be[nwr]   = m_byteenable;
            end
            last_wr_cyc = tcount;
            nwr++;
        end
        @(posedge clk);
        #1;
        tcount++;
        start = 1'b0;
        if (acc) idx++;
        s_valid = (idx < nbytes);
        s_data  = (idx < 16) ? src[idx] : 8'h00;
        if (done) begin
            ndone++;
            done_cyc = tcount;
        end
        #1;
    endtask

    task automatic begin_load(input logic [13:0] base, input logic [15:0] len, input int n);
        nwr   = 0;
        ndone = 0;
        idx   = 0;
        nbytes = n;
        base_addr = base;
        len_bytes = len;
        start     = 1'b1;
        s_valid   = (n > 0);
        s_data    = src[0];
    endtask

    task automatic wait_done(input string name, input int budget);
        int cyc;
        cyc = 0;
        while (ndone == 0 && cyc < budget) begin
            tick();
            cyc++;
        end
        if (ndone == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        logic [7:0]  b;
        logic [31:0] sum;
        int          start_cyc;
        b   = v.b0;
        sum = '0;
        for (int i = 0; i < 16; i++) begin
            src[i] = b;
            if (i < v.exp_consumed) sum = sum + {24'd0, b};
            b = b + v.step;
        end
        mem_grant = 1'b1;
        begin_load(v.base, v.len, int'(v.len));
        start_cyc = tcount;
        wait_done($sformatf("v%0d", vi), 100);
        repeat (3) tick();
        chk($sformatf("v%0d_writes", vi), nwr, v.exp_writes);
        chk($sformatf("v%0d_err", vi), {31'd0, err_overflow}, {31'd0, v.exp_err});
        chk($sformatf("v%0d_consumed", vi), idx, v.exp_consumed);
        chk($sformatf("v%0d_done_pulses", vi), ndone, 1);
        chk($sformatf("v%0d_idle", vi), {30'd0, busy, s_ready}, 32'd0);
        if (v.exp_writes > 0 && nwr == v.exp_writes) begin
            chk($sformatf("v%0d_addr", vi), wr_addr[nwr-1], v.exp_addr_last);
            chk($sformatf("v%0d_data", vi), wr_data[nwr-1], v.exp_data_last);
            chk($sformatf("v%0d_be", vi), wr_be[nwr-1], v.exp_be_last);
            chk($sformatf("v%0d_done_cyc", vi), done_cyc, last_wr_cyc + 1);
        end else begin
            chk($sformatf("v%0d_done_cyc", vi), done_cyc, start_cyc + 1);
        end
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
        chk($sformatf("v%0d_checksum", vi), checksum, sum);
`endif
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_addr"}, m_address, 32'd0);
        chk({name, "_wdata"}, m_writedata, 32'd0);
        chk({name, "_be"}, m_byteenable, 32'd0);
        chk({name, "_ctl"}, {25'd0, m_write, m_chipselect, busy, done, s_ready, err_overflow, 1'b0}, 32'd0);
    endtask

    initial begin
        //         base     len    b0     step  wr last_addr data           be    err cons
        vecs[0] = '{14'h0100, 16'd8, 8'h11, 8'h11, 2, 14'h0101, 32'h88776655, 4'hF, 1'b0, 8};
        vecs[1] = '{14'h0000, 16'd6, 8'hA0, 8'h01, 2, 14'h0001, 32'h0000A5A4, 4'h3, 1'b0, 6};
        vecs[2] = '{14'h27FF, 16'd8, 8'h01, 8'h01, 1, 14'h27FF, 32'h04030201, 4'hF, 1'b1, 4};
        vecs[3] = '{14'h0005, 16'd0, 8'h55, 8'h01, 0, 14'h0000, 32'h00000000, 4'h0, 1'b0, 0};
        vecs[4] = '{14'h2800, 16'd4, 8'h10, 8'h01, 0, 14'h0000, 32'h00000000, 4'h0, 1'b1, 0};
        vecs[5] = '{14'h27FE, 16'd5, 8'hF0, 8'h01, 2, 14'h27FF, 32'h000000F4, 4'h1, 1'b0, 5};
        vecs[6] = '{14'h0010, 16'd3, 8'h5A, 8'h10, 1, 14'h0010, 32'h007A6A5A, 4'h7, 1'b0, 3};
        vecs[7] = '{14'h0300, 16'd4, 8'hFF, 8'h00, 1, 14'h0300, 32'hFFFFFFFF, 4'hF, 1'b0, 4};
        vecs[8] = '{14'h0040, 16'd4, 8'hC1, 8'h01, 1, 14'h0040, 32'hC4C3C2C1, 4'hF, 1'b0, 4};

        tcount = 0; nwr = 0; ndone = 0; idx = 0; nbytes = 0;
        done_cyc = 0; last_wr_cyc = 0;
        for (int i = 0; i < 16; i++) src[i] = 8'h00;
        reset = 1'b1; start = 1'b0; base_addr = '0; len_bytes = '0;
        s_data = '0; s_valid = 1'b0; mem_grant = 1'b0;
        #3;
        chk_all_zero("reset");
`ifdef RAM_STREAM_LOADER_CHECKSUM_EN
        chk("reset_checksum", checksum, 32'd0);
`endif
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #2;

        // Full loads from the table, including the first write of vector 0.
        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
            if (i == 0 && nwr >= 1) begin
                chk("v0_first_addr", wr_addr[0], 32'h0100);
                chk("v0_first_data", wr_data[0], 32'h44332211);
                chk("v0_first_be", wr_be[0], 32'hF);
            end
        end

        // Grant held low for 3 cycles in WRITE.
        for (int i = 0; i < 16; i++) src[i] = 8'(i + 1);
        mem_grant = 1'b0;
        begin_load(14'h0200, 16'd4, 4);
        begin
            int cyc;
            cyc = 0;
            while (!(busy && !s_ready) && cyc < 50) begin
                tick();
                cyc++;
            end
            chk("stall_reach_write", {31'd0, busy && !s_ready}, 32'd1);
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stall%0d_addr", k), m_address, 32'h0200);
            chk($sformatf("stall%0d_data", k), m_writedata, 32'h04030201);
            chk($sformatf("stall%0d_be", k), m_byteenable, 32'hF);
            chk($sformatf("stall%0d_strobe", k), {30'd0, m_write, m_chipselect}, 32'd0);
            chk($sformatf("stall%0d_ready", k), {31'd0, s_ready}, 32'd0);
            tick();
        end
        chk("stall_no_write", nwr, 0);
        mem_grant = 1'b1;
        #1;
        chk("stall_strobe_on_grant", {30'd0, m_write, m_chipselect}, 32'd3);
        #1;
        wait_done("stall", 20);
        chk("stall_writes", nwr, 1);
        chk("stall_done_cyc", done_cyc, last_wr_cyc + 1);
        if (nwr == 1) chk("stall_wdata", wr_data[0], 32'h04030201);
        repeat (2) tick();

        // Reset after two bytes of a word.
        for (int i = 0; i < 16; i++) src[i] = 8'(8'h31 + i);
        begin_load(14'h0040, 16'd8, 8);
        begin
            int cyc;
            cyc = 0;
            while (idx < 2 && cyc < 50) begin
                tick();
                cyc++;
            end
            chk("rst_two_bytes", idx, 2);
        end
        reset = 1'b1;
        #1;
        chk_all_zero("rst_mid");
        repeat (2) begin
            @(posedge clk);
        end
        #2;
        nbytes = 0;
        s_valid = 1'b0;
        reset = 1'b0;
        chk("rst_no_write", nwr, 0);
        @(posedge clk); #2;
        run_vec(8, vecs[8]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule
